// File: rtl/pl_hazard_unit.sv
// Hazard detection and operand-forwarding control for a 5-stage pipeline.
// Shadows the register-usage fields of EX/MEM/WB, raises hold/bubble/flush,
// selects EX operand sources and counts stall/flush cycles (saturating).
module pl_hazard_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16,
    parameter int FORWARDING = 1
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_id_valid,
    input  logic [REG_ADDR_W-1:0] i_id_rs1,
    input  logic [REG_ADDR_W-1:0] i_id_rs2,
    input  logic                  i_id_use_rs1,
    input  logic                  i_id_use_rs2,
    input  logic [REG_ADDR_W-1:0] i_id_rd,
    input  logic                  i_id_reg_write,
    input  logic                  i_id_mem_read,
    input  logic                  i_ex_branch_taken,
    output logic                  o_stall_if,
    output logic                  o_bubble_id,
    output logic                  o_flush,
    output logic [1:0]            o_fwd_a,
    output logic [1:0]            o_fwd_b,
    output logic [CNT_W-1:0]      o_stall_count,
    output logic [CNT_W-1:0]      o_flush_count
);

    // EX needs the full usage record: its sources drive forwarding and its
    // mem_read flag identifies load-use. Past EX only the write side matters.
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic                  use_rs1;
        logic                  use_rs2;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  mem_read;
    } ex_stage_t;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
    } wr_stage_t;

    ex_stage_t             r_ex;
    wr_stage_t             r_mem;
    wr_stage_t             r_wb;
    logic [CNT_W-1:0]      r_stall_cnt;
    logic [CNT_W-1:0]      r_flush_cnt;

    logic [REG_ADDR_W-1:0] w_id_src [2];
    logic [REG_ADDR_W-1:0] w_ex_src [2];
    logic                  w_id_use [2];
    logic                  w_ex_use [2];
    logic [1:0]            w_fwd    [2];
    logic [1:0]            w_hazard;
    logic                  w_stall;
    logic                  w_flush;

    // A stage produces register r only for a real, writing instruction; x0 never counts.
    function automatic logic writes(input logic v, input logic rw,
                                    input logic [REG_ADDR_W-1:0] rd,
                                    input logic [REG_ADDR_W-1:0] r);
        return v & rw & (rd == r) & (rd != '0);
    endfunction

    assign w_id_src[0] = i_id_rs1;
    assign w_id_src[1] = i_id_rs2;
    assign w_id_use[0] = i_id_use_rs1;
    assign w_id_use[1] = i_id_use_rs2;
    assign w_ex_src[0] = r_ex.rs1;
    assign w_ex_src[1] = r_ex.rs2;
    assign w_ex_use[0] = r_ex.use_rs1;
    assign w_ex_use[1] = r_ex.use_rs2;

    // Operand 0 is A (rs1), operand 1 is B (rs2); both follow identical rules.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            logic w_ex_hit;
            assign w_ex_hit = writes(r_ex.valid, r_ex.reg_write, r_ex.rd, w_id_src[gi]);

            if (FORWARDING != 0) begin : g_fwd
                logic w_mem_fwd;
                logic w_wb_fwd;
                assign w_mem_fwd = writes(r_mem.valid, r_mem.reg_write, r_mem.rd, w_ex_src[gi]);
                assign w_wb_fwd  = writes(r_wb.valid, r_wb.reg_write, r_wb.rd, w_ex_src[gi]);
                // Only a load still in EX cannot be bypassed in time.
                assign w_hazard[gi] = i_id_valid & w_id_use[gi] & w_ex_hit & r_ex.mem_read;
                // Youngest producer (MEM) wins over the older one (WB).
                assign w_fwd[gi] = !(r_ex.valid & w_ex_use[gi]) ? 2'b00 :
                                   w_mem_fwd                   ? 2'b10 :
                                   w_wb_fwd                    ? 2'b01 : 2'b00;
            end else begin : g_nofwd
                logic w_mem_hit;
                assign w_mem_hit = writes(r_mem.valid, r_mem.reg_write, r_mem.rd, w_id_src[gi]);
                // WB is covered by the write-through register file.
                assign w_hazard[gi] = i_id_valid & w_id_use[gi] & (w_ex_hit | w_mem_hit);
                assign w_fwd[gi]    = 2'b00;
            end
        end
    endgenerate

    // A taken branch squashes the ID instruction, so it overrides any stall.
    assign w_flush = i_ex_branch_taken;
    assign w_stall = (|w_hazard) & ~i_ex_branch_taken;

    assign o_stall_if    = w_stall;
    assign o_bubble_id   = w_stall;
    assign o_flush       = w_flush;
    assign o_fwd_a       = w_fwd[0];
    assign o_fwd_b       = w_fwd[1];
    assign o_stall_count = r_stall_cnt;
    assign o_flush_count = r_flush_cnt;

    // Advance the shadow pipeline; a stalled or flushed ID enters EX as a bubble.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_ex  <= '0;
            r_mem <= '0;
            r_wb  <= '0;
        end else begin
            r_wb            <= r_mem;
            r_mem.valid     <= r_ex.valid;
            r_mem.rd        <= r_ex.rd;
            r_mem.reg_write <= r_ex.reg_write;
            r_ex.valid      <= i_id_valid & ~(w_stall | w_flush);
            r_ex.rs1        <= i_id_rs1;
            r_ex.rs2        <= i_id_rs2;
            r_ex.use_rs1    <= i_id_use_rs1;
            r_ex.use_rs2    <= i_id_use_rs2;
            r_ex.rd         <= i_id_rd;
            r_ex.reg_write  <= i_id_reg_write;
            r_ex.mem_read   <= i_id_mem_read;
        end
    end

    // Saturating event counters: hold at all-ones instead of wrapping.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (w_flush && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pl_hazard_unit.sv
// Bench for pl_hazard_unit: one forwarding instance (narrow counters so
// saturation is reachable) and one non-forwarding instance share stimulus.
module tb_pl_hazard_unit;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          id_valid = 1'b0, id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
    logic          id_reg_write = 1'b0, id_mem_read = 1'b0, br = 1'b0;
    logic [AW-1:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;

    logic          s1, b1, f1, s0, b0, f0;
    logic [1:0]    fa1, fb1, fa0, fb0;
    logic [3:0]    sc1, fc1;
    logic [15:0]   sc0, fc0;

    always #5 clk = ~clk;

    pl_hazard_unit #(.REG_ADDR_W(AW), .CNT_W(4), .FORWARDING(1)) u_dut1 (
        .i_clk(clk), .i_reset(rst), .i_id_valid(id_valid),
        .i_id_rs1(id_rs1), .i_id_rs2(id_rs2), .i_id_use_rs1(id_use_rs1), .i_id_use_rs2(id_use_rs2),
        .i_id_rd(id_rd), .i_id_reg_write(id_reg_write), .i_id_mem_read(id_mem_read),
        .i_ex_branch_taken(br), .o_stall_if(s1), .o_bubble_id(b1), .o_flush(f1),
        .o_fwd_a(fa1), .o_fwd_b(fb1), .o_stall_count(sc1), .o_flush_count(fc1));

    pl_hazard_unit #(.REG_ADDR_W(AW), .CNT_W(16), .FORWARDING(0)) u_dut0 (
        .i_clk(clk), .i_reset(rst), .i_id_valid(id_valid),
        .i_id_rs1(id_rs1), .i_id_rs2(id_rs2), .i_id_use_rs1(id_use_rs1), .i_id_use_rs2(id_use_rs2),
        .i_id_rd(id_rd), .i_id_reg_write(id_reg_write), .i_id_mem_read(id_mem_read),
        .i_ex_branch_taken(br), .o_stall_if(s0), .o_bubble_id(b0), .o_flush(f0),
        .o_fwd_a(fa0), .o_fwd_b(fb0), .o_stall_count(sc0), .o_flush_count(fc0));

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic drive(input bit r, input bit b, input bit v, input int rs1, input int rs2,
                         input bit u1, input bit u2, input int rd, input bit rw, input bit mr);
        rst = r; br = b; id_valid = v;
        id_rs1 = AW'(rs1); id_rs2 = AW'(rs2); id_use_rs1 = u1; id_use_rs2 = u2;
        id_rd = AW'(rd); id_reg_write = rw; id_mem_read = mr;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        int dut; bit rst; bit br; bit v; int rs1; int rs2; bit u1; bit u2;
        int rd; bit rw; bit mr;
        bit es; bit ef; bit [1:0] efa; bit [1:0] efb; int esc; int efc;
    } vec_t;
    vec_t vecs[$];

    function automatic vec_t mk(int dut, bit r, bit b, bit v, int rs1, int rs2, bit u1, bit u2,
                                int rd, bit rw, bit mr, bit es, bit ef, bit [1:0] fa,
                                bit [1:0] fb, int sc, int fc);
        vec_t t;
        t.dut = dut; t.rst = r; t.br = b; t.v = v; t.rs1 = rs1; t.rs2 = rs2; t.u1 = u1; t.u2 = u2;
        t.rd = rd; t.rw = rw; t.mr = mr; t.es = es; t.ef = ef; t.efa = fa; t.efb = fb;
        t.esc = sc; t.efc = fc;
        return t;
    endfunction

    // ---------------- reference model ----------------
    // pipe[m][k]: instruction k stages past ID (0=EX,1=MEM,2=WB) for mode m.
    typedef struct { bit v; int rs1; int rs2; bit u1; bit u2; int rd; bit rw; bit mr; } inst_t;
    inst_t pipe [2][3];
    int    m_sc [2];
    int    m_fc [2];

    // Distance of the closest in-flight producer of r at or beyond 'first', -1 if none.
    function automatic int nearest(int m, int first, int r);
        for (int k = first; k < 3; k++)
            if (pipe[m][k].v && pipe[m][k].rw && pipe[m][k].rd == r && r != 0) return k;
        return -1;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int k = 0; k < 3; k++) pipe[m][k] = '{default: 0};
            m_sc[m] = 0; m_fc[m] = 0;
        end
    endtask

    task automatic model_check_and_step(input int cyc);
        inst_t id;
        id.v = id_valid; id.rs1 = int'(id_rs1); id.rs2 = int'(id_rs2);
        id.u1 = id_use_rs1; id.u2 = id_use_rs2; id.rd = int'(id_rd);
        id.rw = id_reg_write; id.mr = id_mem_read;
        for (int m = 0; m < 2; m++) begin
            bit         haz = 0;
            bit         stall;
            bit [1:0]   fw [2];
            int         cmax = (m == 1) ? 15 : 65535;
            for (int s = 0; s < 2; s++) begin
                int r  = (s == 0) ? id.rs1 : id.rs2;
                bit u  = (s == 0) ? id.u1 : id.u2;
                int d  = nearest(m, 0, r);
                int er = (s == 0) ? pipe[m][0].rs1 : pipe[m][0].rs2;
                bit eu = (s == 0) ? pipe[m][0].u1 : pipe[m][0].u2;
                int dp;
                if (id.v && u) begin
                    if (m == 1) haz |= (d == 0) && pipe[m][0].mr;
                    else        haz |= (d == 0) || (d == 1);
                end
                fw[s] = 2'b00;
                if (m == 1 && pipe[m][0].v && eu) begin
                    dp = nearest(m, 1, er);
                    if (dp == 1)      fw[s] = 2'b10;
                    else if (dp == 2) fw[s] = 2'b01;
                end
            end
            stall = haz && !br;
            if (m == 1) begin
                chk($sformatf("rnd%0d fwd_outs", cyc), 32'({s1, b1, f1, fa1, fb1}),
                    32'({stall, stall, br, fw[0], fw[1]}));
                chk($sformatf("rnd%0d fwd_counts", cyc), {12'd0, sc1, 12'd0, fc1},
                    {16'(m_sc[m]), 16'(m_fc[m])});
            end else begin
                chk($sformatf("rnd%0d nofwd_outs", cyc), 32'({s0, b0, f0, fa0, fb0}),
                    32'({stall, stall, br, fw[0], fw[1]}));
                chk($sformatf("rnd%0d nofwd_counts", cyc), {sc0, fc0},
                    {16'(m_sc[m]), 16'(m_fc[m])});
            end
            if (stall && m_sc[m] < cmax) m_sc[m]++;
            if (br && m_fc[m] < cmax)    m_fc[m]++;
            pipe[m][2] = pipe[m][1];
            pipe[m][1] = pipe[m][0];
            pipe[m][0] = id;
            if (stall || br) pipe[m][0].v = 0;
        end
    endtask

    initial begin
        // FORWARDING=1: ALU-ALU at distance 1 (fwd 10) and 2 (fwd 01), MEM beats WB.
        vecs.push_back(mk(1,1,0, 0,0,0,0,0, 0,0,0, 0,0,0,0,0,0));
        vecs.push_back(mk(1,0,0, 1,1,2,1,1, 5,1,0, 0,0,0,0,0,0));
        vecs.push_back(mk(1,0,0, 1,5,1,1,1, 6,1,0, 0,0,0,0,0,0));
        vecs.push_back(mk(1,0,0, 0,0,0,0,0, 0,0,0, 0,0,2,0,0,0));
        vecs.push_back(mk(1,0,0, 1,1,1,1,1, 8,1,0, 0,0,0,0,0,0));
        vecs.push_back(mk(1,0,0, 0,0,0,0,0, 0,0,0, 0,0,0,0,0,0));
        vecs.push_back(mk(1,0,0, 1,8,2,1,1,10,1,0, 0,0,0,0,0,0));
        vecs.push_back(mk(1,0,0, 0,0,0,0,0, 0,0,0, 0,0,1,0,0,0));
        vecs.push_back(mk(1,0,0, 1,1,1,1,1, 3,1,0, 0,0,0,0,0,0));
        vecs.push_back(mk(1,0,0, 1,2,2,1,1, 3,1,0, 0,0,0,0,0,0));
        vecs.push_back(mk(1,0,0, 1,3,3,1,1, 4,1,0, 0,0,0,0,0,0));
        vecs.push_back(mk(1,0,0, 0,0,0,0,0, 0,0,0, 0,0,2,2,0,0));
        // FORWARDING=1: load-use stalls once then forwards from WB; x0 never hazards.
        vecs.push_back(mk(1,1,0, 0,0,0,0,0, 0,0,0, 0,0,0,0,0,0));
        vecs.push_back(mk(1,0,0, 1,1,0,1,0, 5,1,1, 0,0,0,0,0,0));
        vecs.push_back(mk(1,0,0, 1,5,5,1,1, 6,1,0, 1,0,0,0,0,0));
        vecs.push_back(mk(1,0,0, 1,5,5,1,1, 6,1,0, 0,0,0,0,1,0));
        vecs.push_back(mk(1,0,0, 0,0,0,0,0, 0,0,0, 0,0,1,1,1,0));
        vecs.push_back(mk(1,0,0, 1,1,0,1,0, 0,1,0, 0,0,0,0,1,0));
        vecs.push_back(mk(1,0,0, 1,0,0,1,1, 6,1,0, 0,0,0,0,1,0));
        vecs.push_back(mk(1,0,0, 1,1,0,1,0, 0,1,1, 0,0,0,0,1,0));
        vecs.push_back(mk(1,0,0, 1,0,0,1,1, 7,1,0, 0,0,0,0,1,0));
        // Load-use coinciding with a taken branch: flush wins, no stall counted.
        vecs.push_back(mk(1,0,0, 1,1,0,1,0, 5,1,1, 0,0,0,0,1,0));
        vecs.push_back(mk(1,0,1, 1,5,5,1,1, 6,1,0, 0,1,0,0,1,0));
        vecs.push_back(mk(1,0,0, 0,0,0,0,0, 0,0,0, 0,0,0,0,1,1));
        // FORWARDING=0: distance 1 stalls twice, distance 2 stalls once, fwd stays 00.
        vecs.push_back(mk(0,1,0, 0,0,0,0,0, 0,0,0, 0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0, 1,1,2,1,1, 5,1,0, 0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0, 1,5,1,1,1, 6,1,0, 1,0,0,0,0,0));
        vecs.push_back(mk(0,0,0, 1,5,1,1,1, 6,1,0, 1,0,0,0,1,0));
        vecs.push_back(mk(0,0,0, 1,5,1,1,1, 6,1,0, 0,0,0,0,2,0));
        vecs.push_back(mk(0,0,0, 1,1,1,1,1, 7,1,0, 0,0,0,0,2,0));
        vecs.push_back(mk(0,0,0, 1,6,1,1,1, 8,1,0, 1,0,0,0,2,0));
        vecs.push_back(mk(0,0,0, 1,6,1,1,1, 8,1,0, 0,0,0,0,3,0));
        vecs.push_back(mk(0,0,0, 0,0,0,0,0, 0,0,0, 0,0,0,0,3,0));

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].br, vecs[i].v, vecs[i].rs1, vecs[i].rs2, vecs[i].u1,
                  vecs[i].u2, vecs[i].rd, vecs[i].rw, vecs[i].mr);
            #1;
            if (vecs[i].dut == 1) begin
                chk($sformatf("vec%0d outs", i), 32'({s1, b1, f1, fa1, fb1}),
                    32'({vecs[i].es, vecs[i].es, vecs[i].ef, vecs[i].efa, vecs[i].efb}));
                chk($sformatf("vec%0d counts", i), {12'd0, sc1, 12'd0, fc1},
                    {16'(vecs[i].esc), 16'(vecs[i].efc)});
                $display("vec %0d dut1 stall=%0d flush=%0d fa=%0d fb=%0d sc=%0d fc=%0d",
                         i, s1, f1, fa1, fb1, sc1, fc1);
            end else begin
                chk($sformatf("vec%0d outs", i), 32'({s0, b0, f0, fa0, fb0}),
                    32'({vecs[i].es, vecs[i].es, vecs[i].ef, vecs[i].efa, vecs[i].efb}));
                chk($sformatf("vec%0d counts", i), {sc0, fc0},
                    {16'(vecs[i].esc), 16'(vecs[i].efc)});
                $display("vec %0d dut0 stall=%0d flush=%0d fa=%0d fb=%0d sc=%0d fc=%0d",
                         i, s0, f0, fa0, fb0, sc0, fc0);
            end
        end

        // Flush counter saturation: 20 taken branches, 4-bit counter stops at 15.
        @(negedge clk); drive(1,0,0,0,0,0,0,0,0,0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); drive(0,1,0,0,0,0,0,0,0,0);
        end
        @(negedge clk); drive(0,0,0,0,0,0,0,0,0,0); #1;
        chk("flush_sat fc1", 32'(fc1), 32'd15);
        chk("flush_cnt fc0", 32'(fc0), 32'd20);
        chk("flush_off f1", 32'(f1), 32'd0);
        $display("seq flush_sat fc1=%0d fc0=%0d", fc1, fc0);

        // Stall counter saturation: 20 load-use pairs, each costing one stall.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); drive(0,0,1,1,0,1,0,5,1,1);
            @(negedge clk); drive(0,0,1,5,5,1,1,6,1,0);
            @(negedge clk); drive(0,0,1,5,5,1,1,6,1,0);
        end
        @(negedge clk); drive(0,0,0,0,0,0,0,0,0,0); #1;
        chk("stall_sat sc1", 32'(sc1), 32'd15);
        chk("stall_sat fc1", 32'(fc1), 32'd15);
        $display("seq stall_sat sc1=%0d fc1=%0d", sc1, fc1);

        // Reset asserted in the middle of a stall cycle clears everything at once.
        @(negedge clk); drive(0,0,1,1,0,1,0,5,1,1);
        @(negedge clk); drive(0,0,1,5,5,1,1,6,1,0); #1;
        chk("midrst pre stall", 32'(s1), 32'd1);
        #2 rst = 1'b1; #1;
        chk("midrst outs", 32'({s1, b1, fa1, fb1}), 32'd0);
        chk("midrst counts", {12'd0, sc1, 12'd0, fc1}, 32'd0);
        @(negedge clk); drive(0,0,1,5,5,1,1,6,1,0); #1;
        chk("postrst no hazard", 32'({s1, b1}), 32'd0);
        $display("seq midrst stall=%0d sc1=%0d fc1=%0d", s1, sc1, fc1);

        // Randomised traffic on a small register set against the model.
        @(negedge clk); drive(1,0,0,0,0,0,0,0,0,0);
        model_reset();
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            drive(0, ($urandom % 8) == 0, ($urandom % 4) != 0,
                  int'($urandom % 4), int'($urandom % 4), $urandom % 2 == 0, $urandom % 2 == 0,
                  int'($urandom % 4), ($urandom % 3) != 0, ($urandom % 3) == 0);
            #1;
            model_check_and_step(i);
            $display("rnd %0d br=%0d s1=%0d fa1=%0d fb1=%0d s0=%0d sc1=%0d sc0=%0d",
                     i, br, s1, fa1, fb1, s0, sc1, sc0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
